// File: rtl/cpu_ce_gate.sv
// cpu_ce_gate: fractional CPU clock-enable with instruction-boundary pause and optional audio fade (CE_GATE_MUTE_EN)
module cpu_ce_gate #(
    parameter int NUM       = 1,
    parameter int DEN       = 16,
    parameter int ACC_W     = 16,
    parameter int DRAIN_MAX = 64,
    parameter int AW        = 16
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 pause_cpu,
    input  logic                 cpu_m1,
    output logic                 cpu_ce,
    output logic                 paused,
    input  logic signed [AW-1:0] audio_in,
    output logic signed [AW-1:0] audio_out
);
    localparam int CW = $clog2(DRAIN_MAX + 1);
    typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_t;
    state_t state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [ACC_W:0] sum;
    logic [CW-1:0] drain_cnt, drain_cnt_nxt;
    logic tick, stop, ce_nxt;
    always_comb begin
        sum = {1'b0, acc} + (ACC_W+1)'(NUM);
        tick = sum >= (ACC_W+1)'(DEN);
        acc_nxt = state == PAUSED ? acc : tick ? ACC_W'(sum - (ACC_W+1)'(DEN)) : ACC_W'(sum);
        stop = tick && (cpu_m1 || drain_cnt == CW'(DRAIN_MAX));
    end
    always_ff @(posedge clk_sys or posedge reset)
        if (reset) begin
            state <= RUN;
            acc <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_nxt;
            acc <= acc_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    // a pause release always wins over a stop decided on the same edge
    always_comb
        state_nxt = state == RUN   ? (pause_cpu ? DRAIN : RUN) :
                    state == DRAIN ? (!pause_cpu ? RUN : stop ? PAUSED : DRAIN) :
                                     (pause_cpu ? PAUSED : RUN);
    always_comb begin
        ce_nxt = state != PAUSED && tick && !(state == DRAIN && pause_cpu && stop);
        drain_cnt_nxt = state == RUN ? '0 : state == DRAIN && tick && !stop ? drain_cnt + 1'b1 : drain_cnt;
    end
    always_ff @(posedge clk_sys or posedge reset)
        if (reset) begin
            cpu_ce <= 1'b0;
            paused <= 1'b0;
        end else begin
            cpu_ce <= ce_nxt;
            paused <= state_nxt == PAUSED;
        end
`ifdef CE_GATE_MUTE_EN
    logic [7:0] fade_cnt;
    logic signed [AW-1:0] half;
    assign half = audio_out >>> 1;
    // halve once per fade period; -1 would stick under arithmetic shift, so force it to 0
    always_ff @(posedge clk_sys or posedge reset)
        if (reset) begin
            fade_cnt <= '0;
            audio_out <= '0;
        end else if (!paused) begin
            fade_cnt <= '0;
            audio_out <= audio_in;
        end else begin
            fade_cnt <= fade_cnt + 8'd1;
            if (fade_cnt == 8'hff)
                audio_out <= half == '1 ? '0 : half;
        end
`else
    always_ff @(posedge clk_sys or posedge reset)
        if (reset)
            audio_out <= '0;
        else
            audio_out <= audio_in;
`endif
endmodule

// File: tb/tb_cpu_ce_gate.sv
// tb_cpu_ce_gate: randomized scoreboard bench; reference model derives ticks from floor(k*NUM/DEN)
module tb_cpu_ce_gate;
    localparam int NUM = 3, DEN = 16, DMAX = 4, AW = 16;
    logic clk_sys = 1'b0, reset = 1'b1, pause_cpu = 1'b0, cpu_m1 = 1'b0;
    logic cpu_ce, paused;
    logic signed [AW-1:0] audio_in = '0, audio_out;
    int checks = 0, failures = 0;
    typedef struct packed {
        logic ce;
        logic p;
        logic signed [AW-1:0] a;
    } exp_t;
    exp_t q[$];
    exp_t e;
    longint k;
    int mode, dcnt, fade;
    logic m_ce, m_p;
    logic signed [AW-1:0] m_a;

    cpu_ce_gate #(.NUM(NUM), .DEN(DEN), .DRAIN_MAX(DMAX), .AW(AW)) dut (
        .clk_sys(clk_sys), .reset(reset), .pause_cpu(pause_cpu), .cpu_m1(cpu_m1),
        .cpu_ce(cpu_ce), .paused(paused), .audio_in(audio_in), .audio_out(audio_out)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(string name, longint got, longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // mode: 0 run, 1 drain, 2 paused; k counts divider advances since reset
    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            k = 0; mode = 0; dcnt = 0; fade = 0;
            m_ce = 0; m_p = 0; m_a = '0;
            q.delete();
        end else begin
            bit t;
            int a;
            a = m_a;
`ifdef CE_GATE_MUTE_EN
            if (!m_p) begin
                a = audio_in;
                fade = 0;
            end else begin
                fade = (fade + 1) % 256;
                if (fade == 0) begin
                    a = a < 0 ? -((1 - a) / 2) : a / 2;
                    if (a == -1) a = 0;
                end
            end
`else
            a = audio_in;
`endif
            t = mode != 2 && ((k + 1) * NUM / DEN) != (k * NUM / DEN);
            if (mode != 2) k++;
            m_ce = 0;
            if (mode == 0) begin
                m_ce = t;
                if (pause_cpu) begin mode = 1; dcnt = 0; end
            end else if (mode == 1) begin
                if (!pause_cpu) begin m_ce = t; mode = 0; end
                else if (t && (cpu_m1 || dcnt == DMAX)) mode = 2;
                else begin m_ce = t; dcnt += int'(t); end
            end else if (!pause_cpu) mode = 0;
            m_p = mode == 2;
            m_a = a[AW-1:0];
            q.push_back('{m_ce, m_p, m_a});
        end
    end

    always @(negedge clk_sys)
        if (!reset && q.size() > 0) begin
            e = q.pop_front();
            chk("cpu_ce", cpu_ce, e.ce);
            chk("paused", paused, e.p);
            chk("audio_out", audio_out, e.a);
            if (cpu_ce) chk("ce_and_paused", paused, 0);
        end

    initial begin
        int ce_n, max_gap, last, dbl, w;
        cyc(2);
        chk("rst_cpu_ce", cpu_ce, 0);
        chk("rst_paused", paused, 0);
        chk("rst_audio", audio_out, 0);
        reset = 1'b0;
        ce_n = 0; max_gap = 0; last = 0; dbl = 0;
        for (int i = 1; i <= 1600; i++) begin
            @(negedge clk_sys);
            if (cpu_ce) begin
                ce_n++;
                if (last > 0 && i - last > max_gap) max_gap = i - last;
                if (i - last == 1) dbl++;
                last = i;
            end
            audio_in = AW'($urandom);
        end
        chk("rate_count", ce_n, 300);
        chk("rate_max_gap_le6", max_gap <= 6, 1);
        chk("rate_wide_pulse", dbl, 0);

        pause_cpu = 1'b1; cpu_m1 = 1'b0; ce_n = 0;
        @(negedge clk_sys);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_sys);
            ce_n += int'(cpu_ce);
        end
        chk("timeout_ces", ce_n, DMAX);
        chk("timeout_paused", paused, 1);
        pause_cpu = 1'b0;
        cyc(10);

        pause_cpu = 1'b1;
        cyc(3);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_ce", cpu_ce, 0);
        chk("async_rst_paused", paused, 0);
        chk("async_rst_audio", audio_out, 0);
        @(negedge clk_sys);
        reset = 1'b0; pause_cpu = 1'b0;

        for (int i = 0; i < 6000; i++) begin
            @(negedge clk_sys);
            if ($urandom_range(0, 39) == 0) pause_cpu = ~pause_cpu;
            cpu_m1 = $urandom_range(0, i < 3000 ? 3 : 15) == 0;
            audio_in = AW'($urandom);
        end
        pause_cpu = 1'b0;
        cyc(5);

`ifdef CE_GATE_MUTE_EN
        audio_in = 16'sh4000; cpu_m1 = 1'b1;
        cyc(3);
        pause_cpu = 1'b1;
        w = 0;
        while (!paused && w < 200) begin
            @(negedge clk_sys);
            w++;
        end
        chk("mute_paused", paused, 1);
        cyc(256);
        chk("fade_once", audio_out, 16'sh2000);
        cyc(14 * 256);
        chk("fade_silent", audio_out, 0);
        pause_cpu = 1'b0;
        cyc(3);
        chk("unmute", audio_out, 16'sh4000);
`else
        w = 0;
`endif
        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
